// File: rtl/ahb_slave_arbiter_multimode.sv
// Slave-side AHB arbiter: fixed, dynamic-priority or round-robin selection,
// re-arbitrating only at burst boundaries, with a hold limit on INCR bursts.
module ahb_slave_arbiter_multimode #(
  parameter int MASTER_NUM = 4,
  parameter int PRIOR_BIT  = 2,
  parameter int ARB_MODE   = 0,
  parameter int MAX_HOLD   = 16,
  parameter int IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic                            hclk,
  input  logic                            hreset,
  input  logic [MASTER_NUM-1:0]           hreq,
  input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
  input  logic [2:0]                      hburst,
  input  logic                            hwait,
  output logic [MASTER_NUM-1:0]           hgrant,
  output logic                            hsel,
  output logic [IDX_W-1:0]                hmaster,
  output logic                            hlast
);

  localparam int CNT_W = (MAX_HOLD > 16) ? $clog2(MAX_HOLD) : 4;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_WRAP4  = 3'd2;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_WRAP8  = 3'd4;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_WRAP16 = 3'd6;
  localparam logic [2:0] B_INCR16 = 3'd7;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [MASTER_NUM-1:0]   grant;
  logic [MASTER_NUM-1:0]   grant_nxt;
  logic [MASTER_NUM-1:0]   win;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        owner;
  logic                    found;
  logic [PRIOR_BIT-1:0]    best;
  int                      rr_idx;
  logic [2:0]              burst_q;
  logic [2:0]              burst_cur;
  logic                    first;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_nxt;
  logic [CNT_W-1:0]        limit;
  logic                    is_incr;
  logic                    owner_req;
  logic                    accept;
  logic                    load;

  always_comb begin
    found   = 1'b0;
    best    = '0;
    win_idx = '0;
    rr_idx  = 0;
    win     = '0;
    if (ARB_MODE == 2) begin
      for (int k = 1; k <= MASTER_NUM; k++) begin
        rr_idx = (int'(rr_ptr) + k) % MASTER_NUM;
        if (!found && hreq[rr_idx]) begin
          found   = 1'b1;
          win_idx = IDX_W'(rr_idx);
        end
      end
    end else if (ARB_MODE == 1) begin
      // strict compare keeps ties on the lowest index
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (hreq[i] &&
            (!found || hprior[i*PRIOR_BIT +: PRIOR_BIT] > best)) begin
          found   = 1'b1;
          best    = hprior[i*PRIOR_BIT +: PRIOR_BIT];
          win_idx = IDX_W'(i);
        end
      end
    end else begin
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
        if (hreq[i]) begin
          found   = 1'b1;
          win_idx = IDX_W'(i);
        end
      end
    end
    if (found) win[win_idx] = 1'b1;
  end

  always_comb begin
    owner = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant[i]) owner = IDX_W'(i);
    end
  end

  // first beat still sees the live burst type until it is latched
  assign burst_cur = first ? hburst : burst_q;
  assign is_incr   = (burst_cur == B_INCR);
  assign owner_req = hreq[owner];

  always_comb begin
    limit = '0;
    unique case (burst_cur)
      B_SINGLE, B_INCR:  limit = '0;
      B_WRAP4, B_INCR4:  limit = CNT_W'(3);
      B_WRAP8, B_INCR8:  limit = CNT_W'(7);
      B_WRAP16, B_INCR16: limit = CNT_W'(15);
      default:           limit = '0;
    endcase
  end

  always_comb begin
    hlast = 1'b0;
    if (state == BUSY) begin
      if (is_incr) hlast = (count == HOLD_LIM) | ~owner_req;
      else         hlast = (count == limit);
    end
  end

  assign accept  = hlast & ~hwait;
  assign load    = (state == IDLE) | accept;
  assign hsel    = |grant;
  assign hgrant  = grant & {MASTER_NUM{~hwait}};
  assign hmaster = owner;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    count_nxt = count;
    if (load) grant_nxt = win;
    unique case (state)
      IDLE: begin
        count_nxt = '0;
        if (|win) state_nxt = BUSY;
      end
      BUSY: begin
        if (accept) begin
          count_nxt = '0;
          state_nxt = (|win) ? BUSY : IDLE;
        end else if (!hwait) begin
          count_nxt = count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= IDLE;
      grant   <= '0;
      count   <= '0;
      burst_q <= '0;
      first   <= 1'b0;
      rr_ptr  <= IDX_W'(MASTER_NUM - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      count <= count_nxt;
      if (load && (|win)) rr_ptr <= win_idx;
      if (state == BUSY && first) burst_q <= hburst;
      if (load)        first <= |win;
      else if (!hwait) first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter_multimode.sv
// Random and directed bench for all three arbitration modes against a
// transaction-level model of owner, beats done and rotation pointer.
module tb_ahb_slave_arbiter_multimode;

  logic       clk;
  logic       hreset;
  logic [3:0] hreq;
  logic [7:0] hprior;
  logic       hwait;
  logic [2:0] hburst_i  [3];
  logic [3:0] hgrant_o  [3];
  logic       hsel_o    [3];
  logic [1:0] hmaster_o [3];
  logic       hlast_o   [3];

  int checks;
  int fails;
  bit armed;

  int own  [3];
  int beats[3];
  int stb  [3];
  int rrp  [3];
  int hold [3] = '{4, 5, 16};
  logic [2:0] mburst[4];

  ahb_slave_arbiter_multimode #(
    .MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(0), .MAX_HOLD(4)
  ) u_fix (
    .hclk(clk), .hreset(hreset), .hreq(hreq), .hprior(hprior),
    .hburst(hburst_i[0]), .hwait(hwait), .hgrant(hgrant_o[0]),
    .hsel(hsel_o[0]), .hmaster(hmaster_o[0]), .hlast(hlast_o[0])
  );

  ahb_slave_arbiter_multimode #(
    .MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(1), .MAX_HOLD(5)
  ) u_dyn (
    .hclk(clk), .hreset(hreset), .hreq(hreq), .hprior(hprior),
    .hburst(hburst_i[1]), .hwait(hwait), .hgrant(hgrant_o[1]),
    .hsel(hsel_o[1]), .hmaster(hmaster_o[1]), .hlast(hlast_o[1])
  );

  ahb_slave_arbiter_multimode #(
    .MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(2), .MAX_HOLD(16)
  ) u_rr (
    .hclk(clk), .hreset(hreset), .hreq(hreq), .hprior(hprior),
    .hburst(hburst_i[2]), .hwait(hwait), .hgrant(hgrant_o[2]),
    .hsel(hsel_o[2]), .hmaster(hmaster_o[2]), .hlast(hlast_o[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int blen_of(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return 0;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic int winner(input int m, input logic [3:0] r);
    int w;
    int bp;
    int p;
    int i;
    w  = -1;
    bp = -1;
    for (int k = 0; k < 4; k++) begin
      case (m)
        0: i = k;
        1: i = k;
        default: i = (rrp[m] + 1 + k) % 4;
      endcase
      if (r[i]) begin
        if (m == 1) begin
          p = int'(hprior[2*i +: 2]);
          if (p > bp) begin
            bp = p;
            w  = i;
          end
        end else if (w < 0) begin
          w = i;
        end
      end
    end
    return w;
  endfunction

  function automatic bit exp_last(input int m);
    int L;
    if (own[m] < 0) return 1'b0;
    L = (beats[m] == 0) ? blen_of(hburst_i[m]) : stb[m];
    if (L == 0) return (beats[m] == hold[m] - 1) || !hreq[own[m]];
    return beats[m] == L - 1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      own[m]   = -1;
      beats[m] = 0;
      stb[m]   = 0;
      rrp[m]   = 3;
    end
  endtask

  task automatic model_update(input int m);
    int w;
    bit last;
    w    = winner(m, hreq);
    last = exp_last(m);
    if (own[m] < 0) begin
      if (w >= 0) begin
        own[m]   = w;
        beats[m] = 0;
        rrp[m]   = w;
      end
    end else if (!hwait) begin
      if (last) begin
        own[m]   = w;
        beats[m] = 0;
        if (w >= 0) rrp[m] = w;
      end else begin
        if (beats[m] == 0) stb[m] = blen_of(hburst_i[m]);
        beats[m]++;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic w, input logic rst);
    logic [3:0] eg;
    hreq   = r;
    hwait  = w;
    hreset = rst;
    for (int m = 0; m < 3; m++)
      hburst_i[m] = (own[m] >= 0) ? mburst[own[m]] : mburst[0];
    #1;
    if (armed) begin
      for (int m = 0; m < 3; m++) begin
        eg = '0;
        if (own[m] >= 0 && !w) eg[own[m]] = 1'b1;
        check($sformatf("m%0d_hgrant", m), 32'(hgrant_o[m]), 32'(eg));
        check($sformatf("m%0d_hsel", m), 32'(hsel_o[m]),
              32'(own[m] >= 0));
        check($sformatf("m%0d_hmaster", m), 32'(hmaster_o[m]),
              (own[m] >= 0) ? 32'(own[m]) : 32'd0);
        check($sformatf("m%0d_hlast", m), 32'(hlast_o[m]),
              32'(exp_last(m)));
      end
    end
    if (rst) begin
      model_reset();
      armed = 1'b1;
    end else begin
      for (int m = 0; m < 3; m++) model_update(m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_bursts(input logic [2:0] b);
    for (int i = 0; i < 4; i++) mburst[i] = b;
  endtask

  logic [3:0] rr_seq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] req_r;
  logic [3:0] tg;

  initial begin
    checks = 0;
    fails  = 0;
    armed  = 1'b0;
    hprior = '0;
    model_reset();
    set_bursts(3'd0);

    // fixed priority, single beats
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    check("t1_hgrant", 32'(hgrant_o[0]), 32'h2);
    check("t1_hmaster", 32'(hmaster_o[0]), 32'd1);
    check("t1_hlast", 32'(hlast_o[0]), 32'd1);
    step(4'b0100, 1'b0, 1'b0);
    check("t1_regrant", 32'(hgrant_o[0]), 32'h4);

    // round-robin rotation
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      check("t2_rr", 32'(hgrant_o[2]), 32'(rr_seq[i]));
    end

    // dynamic priority tie
    hprior = {2'd3, 2'd1, 2'd3, 2'd0};
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    check("t3_dyn", 32'(hgrant_o[1]), 32'h2);

    // INCR4 with wait states
    set_bursts(3'd3);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0011, 1'b0, 1'b0);

    // INCR hold limit in round-robin
    set_bursts(3'd1);
    hprior = '0;
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(4'b0011, 1'b0, 1'b0);
    check("t5_owner", 32'(hmaster_o[2]), 32'd0);
    check("t5_hlast", 32'(hlast_o[2]), 32'd1);
    step(4'b0011, 1'b0, 1'b0);
    check("t5_next", 32'(hmaster_o[2]), 32'd1);

    // reset in the middle of INCR8
    set_bursts(3'd5);
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    for (int m = 0; m < 3; m++) begin
      check("t6_hsel", 32'(hsel_o[m]), 32'd0);
      check("t6_hgrant", 32'(hgrant_o[m]), 32'd0);
      check("t6_hlast", 32'(hlast_o[m]), 32'd0);
    end
    step(4'b0001, 1'b0, 1'b0);
    check("t6_regrant", 32'(hgrant_o[0]), 32'h1);

    // idle with no requests
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);

    // random traffic
    req_r = '0;
    for (int n = 0; n < 4000; n++) begin
      tg    = 4'($urandom) & 4'($urandom);
      req_r = req_r ^ tg;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) mburst[i] = 3'($urandom);
      if ($urandom_range(0, 15) == 0) hprior = 8'($urandom);
      step(req_r, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
